// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular add/subtract for the inverse-NTT butterfly.
// S1 registers the raw 65-bit sum and difference. S2 reduces them into [0, M-1] and drives the outputs.
module mod_addsub_pipe #(
    parameter int unsigned           data_width = 64,
    parameter logic [data_width-1:0] M          = 64'hffff_ffff_0000_0001,
    parameter int unsigned           tag_width  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [data_width-1:0] a_in,
    input  logic [data_width-1:0] b_in,
    input  logic [tag_width-1:0]  tag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] sum_out,
    output logic [data_width-1:0] diff_out,
    output logic [tag_width-1:0]  tag_out
);

    localparam logic [data_width:0] M_EXT = {1'b0, M};

    logic                  s1_valid_q, s1_valid_d;
    logic [data_width:0]   s1_sum_q, s1_sum_d;
    logic [data_width:0]   s1_diff_q, s1_diff_d;
    logic [tag_width-1:0]  s1_tag_q, s1_tag_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [data_width-1:0] s2_sum_q, s2_sum_d;
    logic [data_width-1:0] s2_diff_q, s2_diff_d;
    logic [tag_width-1:0]  s2_tag_q, s2_tag_d;
    logic                  s1_adv_s, s2_adv_s;
    logic [data_width-1:0] red_sum_s, red_diff_s;

    // Advance control: a stage moves when it is empty or its successor moves.
    always_comb begin
        s2_adv_s = !s2_valid_q || out_ready;
        s1_adv_s = !s1_valid_q || s2_adv_s;
    end

    assign in_ready  = s1_adv_s;
    assign out_valid = s2_valid_q;
    assign sum_out   = s2_sum_q;
    assign diff_out  = s2_diff_q;
    assign tag_out   = s2_tag_q;

    // Final reduction; low bits of the 65-bit subtraction equal the truncated one.
    always_comb begin
        if (s1_sum_q >= M_EXT) begin
            red_sum_s = s1_sum_q[data_width-1:0] - M;
        end else begin
            red_sum_s = s1_sum_q[data_width-1:0];
        end
        if (s1_diff_q[data_width]) begin
            red_diff_s = s1_diff_q[data_width-1:0] + M;
        end else begin
            red_diff_s = s1_diff_q[data_width-1:0];
        end
    end

    // S1 next state: capture raw sum and borrow-extended difference.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_diff_d  = s1_diff_q;
        s1_tag_d   = s1_tag_q;
        if (s1_adv_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sum_d  = {1'b0, a_in} + {1'b0, b_in};
                s1_diff_d = {1'b0, a_in} - {1'b0, b_in};
                s1_tag_d  = tag_in;
            end else begin
                s1_sum_d  = s1_sum_q;
                s1_diff_d = s1_diff_q;
                s1_tag_d  = s1_tag_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: load reduced results only when S1 holds a pair.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_diff_d  = s2_diff_q;
        s2_tag_d   = s2_tag_q;
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d  = red_sum_s;
                s2_diff_d = red_diff_s;
                s2_tag_d  = s1_tag_q;
            end else begin
                s2_sum_d  = s2_sum_q;
                s2_diff_d = s2_diff_q;
                s2_tag_d  = s2_tag_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; reset discards any in-flight pairs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= {(data_width+1){1'b0}};
            s1_diff_q  <= {(data_width+1){1'b0}};
            s1_tag_q   <= {tag_width{1'b0}};
            s2_valid_q <= 1'b0;
            s2_sum_q   <= {data_width{1'b0}};
            s2_diff_q  <= {data_width{1'b0}};
            s2_tag_q   <= {tag_width{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_diff_q  <= s1_diff_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_diff_q  <= s2_diff_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Scoreboard bench for mod_addsub_pipe: driver pushes expected results, monitor pops on each output transfer.
module tb_mod_addsub_pipe;

    localparam logic [63:0] MOD = 64'hffff_ffff_0000_0001;

    typedef struct {
        logic [63:0] s;
        logic [63:0] d;
        logic [7:0]  t;
        int          cyc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a_in = 64'd0;
    logic [63:0] b_in = 64'd0;
    logic [7:0]  tag_in = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] sum_out;
    logic [63:0] diff_out;
    logic [7:0]  tag_out;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   lat_mode = 1'b0;

    mod_addsub_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_out(sum_out), .diff_out(diff_out), .tag_out(tag_out)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain modular arithmetic on wide integers
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic [7:0] t);
        exp_t r;
        logic [127:0] wa, wb, wm, rs, rd;
        wa = {64'd0, a};
        wb = {64'd0, b};
        wm = {64'd0, MOD};
        rs = (wa + wb) % wm;
        rd = (wa + wm - wb) % wm;
        r.s = rs[63:0];
        r.d = rd[63:0];
        r.t = t;
        r.cyc = 0;
        r.lat = 1'b0;
        return r;
    endfunction

    function automatic logic [63:0] rnd_op();
        logic [127:0] x;
        case ($urandom_range(0, 7))
            0: return MOD - 64'd1;
            1: return 64'd0;
            default: begin
                x = {64'd0, $urandom, $urandom};
                x = x % {64'd0, MOD};
                return x[63:0];
            end
        endcase
    endfunction

    task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b, input logic [7:0] t,
                        input logic ordy, input logic use_exp, input logic [63:0] es,
                        input logic [63:0] ed, output logic fired);
        exp_t e;
        @(negedge clk);
        in_valid = v; a_in = a; b_in = b; tag_in = t; out_ready = ordy;
        #1;
        fired = in_valid && in_ready;
        if (fired) begin
            e = model(a, b, t);
            if (use_exp) begin
                e.s = es;
                e.d = ed;
            end
            e.cyc = cyc;
            e.lat = lat_mode;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [7:0] t,
                        input logic use_exp, input logic [63:0] es, input logic [63:0] ed);
        logic f;
        f = 1'b0;
        for (int i = 0; i < 100 && !f; i++) step(1'b1, a, b, t, 1'b1, use_exp, es, ed, f);
        chk("send_accepted", {63'd0, f}, 64'd1);
    endtask

    task automatic drain(input int n);
        logic f;
        for (int i = 0; i < n; i++) step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1, 1'b0, 64'd0, 64'd0, f);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: output checks, stall stability and latency
    initial begin
        exp_t e;
        bit prev_stall;
        logic [63:0] ps, pd;
        logic [7:0] pt;
        prev_stall = 1'b0;
        ps = 64'd0; pd = 64'd0; pt = 8'd0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                chk("no_x", {63'd0, $isunknown({out_valid, in_ready, sum_out, diff_out, tag_out})}, 64'd0);
                if (prev_stall) begin
                    chk("stall_valid", {63'd0, out_valid}, 64'd1);
                    chk("stall_sum", sum_out, ps);
                    chk("stall_diff", diff_out, pd);
                    chk("stall_tag", {56'd0, tag_out}, {56'd0, pt});
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("sum", sum_out, e.s);
                        chk("diff", diff_out, e.d);
                        chk("tag", {56'd0, tag_out}, {56'd0, e.t});
                        if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
                    end
                end
                prev_stall = out_valid && !out_ready;
                ps = sum_out; pd = diff_out; pt = tag_out;
            end
        end
    end

    initial begin
        logic f;
        int nacc, ncyc;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", sum_out, 64'd0);
        chk("rst_diff", diff_out, 64'd0);
        chk("rst_tag", {56'd0, tag_out}, 64'd0);
        #2 rst_n = 1'b1;
        step(1'b0, 64'd0, 64'd0, 8'd0, 1'b1, 1'b0, 64'd0, 64'd0, f);
        chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

        lat_mode = 1'b1;
        send(MOD - 64'd1, 64'd1, 8'h11, 1'b1, 64'd0, 64'hffff_fffe_ffff_ffff);
        send(64'd0, 64'd1, 8'h22, 1'b1, 64'd1, 64'hffff_ffff_0000_0000);
        send(MOD - 64'd1, MOD - 64'd1, 8'h33, 1'b1, 64'hffff_fffe_ffff_ffff, 64'd0);
        send(64'd5, 64'd3, 8'h44, 1'b1, 64'd8, 64'd2);
        drain(4);

        for (int i = 0; i < 64; i++) begin
            step(1'b1, rnd_op(), rnd_op(), 8'(i), 1'b1, 1'b0, 64'd0, 64'd0, f);
            chk("stream_accept", {63'd0, f}, 64'd1);
        end
        drain(4);
        lat_mode = 1'b0;

        nacc = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, rnd_op(), rnd_op(), 8'(8'hb0 + i), 1'b0, 1'b0, 64'd0, 64'd0, f);
            nacc += int'(f);
            if (i >= 2) chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        chk("bp_accepts", 64'(nacc), 64'd2);
        drain(6);

        nacc = 0;
        ncyc = 0;
        while (nacc < 10000 && ncyc < 60000) begin
            step(1'($urandom), rnd_op(), rnd_op(), 8'($urandom), 1'($urandom), 1'b0, 64'd0, 64'd0, f);
            nacc += int'(f);
            ncyc++;
        end
        chk("rand_accepted", 64'(nacc), 64'd10000);
        drain(6);

        step(1'b1, rnd_op(), rnd_op(), 8'hc1, 1'b0, 1'b0, 64'd0, 64'd0, f);
        step(1'b1, rnd_op(), rnd_op(), 8'hc2, 1'b0, 1'b0, 64'd0, 64'd0, f);
        step(1'b0, 64'd0, 64'd0, 8'd0, 1'b0, 1'b0, 64'd0, 64'd0, f);
        chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_sum", sum_out, 64'd0);
        chk("midrst_diff", diff_out, 64'd0);
        chk("midrst_tag", {56'd0, tag_out}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        sb.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        lat_mode = 1'b1;
        send(64'd10, 64'd20, 8'h5a, 1'b1, 64'd30, 64'hffff_fffe_ffff_fff7);
        drain(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
